// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Pipeline execute stage. Computes the ALU result, zero flag,
//                branch target and destination register, and registers them
//                with the forwarded control bits as the EX/MEM boundary.
//                MULT (and DIVU when EX_DIV_EN is defined) run iteratively,
//                one step per cycle, while stall holds the ID/EX latch.
//  Options     : `define EX_DIV_EN to build the iterative unsigned divider;
//                without it DIVU decodes as an unknown op (result 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int W     = 32,
    parameter int ITERS = 32    // one multiply/divide step per bit; keep equal to W
) (
    input  logic         clk,
    input  logic         rst,               // asynchronous, active-low
    input  logic         flush,
    input  logic         branch,
    input  logic         jump,
    input  logic         AluSrc,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic         RegWrite,
    input  logic         RegDst,
    input  logic         MemtoReg,
    input  logic [5:0]   AluOp,
    input  logic [W-1:0] npc,
    input  logic [W-1:0] readdata1,
    input  logic [W-1:0] readdata2,
    input  logic [W-1:0] sigext,
    input  logic [4:0]   instruction_2016,
    input  logic [4:0]   instruction_1511,
    output logic         stall,
    output logic         branch_out,
    output logic         jump_out,
    output logic         MemRead_out,
    output logic         MemWrite_out,
    output logic         RegWrite_out,
    output logic         MemtoReg_out,
    output logic [W-1:0] alu_result_out,
    output logic         zero_out,
    output logic [W-1:0] branch_target_out,
    output logic [W-1:0] readdata2_out,
    output logic [4:0]   write_reg_out
);

    localparam logic [5:0] c_OP_SLL  = 6'h00;
    localparam logic [5:0] c_OP_SRL  = 6'h02;
    localparam logic [5:0] c_OP_MULT = 6'h18;
    localparam logic [5:0] c_OP_DIVU = 6'h1A;
    localparam logic [5:0] c_OP_ADD  = 6'h20;
    localparam logic [5:0] c_OP_SUB  = 6'h22;
    localparam logic [5:0] c_OP_AND  = 6'h24;
    localparam logic [5:0] c_OP_OR   = 6'h25;
    localparam logic [5:0] c_OP_XOR  = 6'h26;
    localparam logic [5:0] c_OP_NOR  = 6'h27;
    localparam logic [5:0] c_OP_SLT  = 6'h2A;

    localparam int              c_CW   = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    // MULT: r_a multiplicand (shifts left), r_b multiplier (shifts right), r_acc product.
    // DIVU: r_a divisor, r_b dividend shifting out / quotient shifting in, r_acc remainder.
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    // Control and data of the long op, held for the DONE writeback.
    logic [5:0]      r_h_ctl;   // {branch, jump, MemRead, MemWrite, RegWrite, MemtoReg}
    logic [W-1:0]    r_h_tgt;
    logic [W-1:0]    r_h_rd2;
    logic [4:0]      r_h_wreg;

    logic [W-1:0]    w_opb;
    logic [4:0]      w_shamt;
    logic            w_slt;
    logic [W-1:0]    w_alu;
    logic [W-1:0]    w_target;
    logic [4:0]      w_wreg;
    logic            w_is_iter;
    logic            w_bubble;
    logic [W-1:0]    w_mul_acc_nxt;
    logic [W-1:0]    w_iter_res;

    assign w_opb    = AluSrc ? sigext : readdata2;
    assign w_shamt  = sigext[10:6];
    assign w_slt    = $signed(readdata1) < $signed(w_opb);
    assign w_target = npc + (sigext << 2);
    assign w_wreg   = RegDst ? instruction_1511 : instruction_2016;

    assign w_mul_acc_nxt = r_b[0] ? (r_acc + r_a) : r_acc;

`ifdef EX_DIV_EN
    logic         r_is_div;
    logic [W:0]   w_rem_sh;
    logic         w_rem_ge;
    logic [W:0]   w_rem_sub;
    logic [W-1:0] w_rem_nxt;

    // Restoring division step: shift the next dividend bit into the remainder,
    // subtract the divisor when it fits. A zero divisor always fits, so the
    // quotient saturates to all-ones.
    assign w_rem_sh  = {r_acc, r_b[W-1]};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_a});
    assign w_rem_sub = w_rem_sh - {1'b0, r_a};
    assign w_rem_nxt = w_rem_ge ? w_rem_sub[W-1:0] : w_rem_sh[W-1:0];

    assign w_is_iter  = (AluOp == c_OP_MULT) || (AluOp == c_OP_DIVU);
    assign w_iter_res = r_is_div ? r_b : r_acc;
`else
    assign w_is_iter  = (AluOp == c_OP_MULT);
    assign w_iter_res = r_acc;
`endif

    // Stall while a long op is being issued or iterated; flush and reset release it.
    assign stall = rst && !flush &&
                   ((r_state == S_BUSY) || ((r_state == S_IDLE) && w_is_iter));

    // EX/MEM takes a bubble whenever nothing valid completes this cycle.
    assign w_bubble = flush || (r_state == S_BUSY) || ((r_state == S_IDLE) && w_is_iter);

    // Single-cycle ALU; DIVU falls to the default when the divider is absent.
    always_comb begin
        w_alu = '0;
        case (AluOp)
            c_OP_ADD: w_alu = readdata1 + w_opb;
            c_OP_SUB: w_alu = readdata1 - w_opb;
            c_OP_AND: w_alu = readdata1 & w_opb;
            c_OP_OR:  w_alu = readdata1 | w_opb;
            c_OP_XOR: w_alu = readdata1 ^ w_opb;
            c_OP_NOR: w_alu = ~(readdata1 | w_opb);
            c_OP_SLT: w_alu = {{(W-1){1'b0}}, w_slt};
            c_OP_SLL: w_alu = w_opb << w_shamt;
            c_OP_SRL: w_alu = w_opb >> w_shamt;
            default:  w_alu = '0;
        endcase
    end

    // Iterative-op controller: issue, one step per BUSY cycle, single DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_h_ctl  <= '0;
            r_h_tgt  <= '0;
            r_h_rd2  <= '0;
            r_h_wreg <= '0;
`ifdef EX_DIV_EN
            r_is_div <= 1'b0;
`endif
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_iter) begin
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_h_ctl  <= {branch, jump, MemRead, MemWrite, RegWrite, MemtoReg};
                        r_h_tgt  <= w_target;
                        r_h_rd2  <= readdata2;
                        r_h_wreg <= w_wreg;
                        r_state  <= S_BUSY;
`ifdef EX_DIV_EN
                        r_is_div <= (AluOp == c_OP_DIVU);
                        if (AluOp == c_OP_DIVU) begin
                            r_a <= w_opb;
                            r_b <= readdata1;
                        end else begin
                            r_a <= readdata1;
                            r_b <= w_opb;
                        end
`else
                        r_a <= readdata1;
                        r_b <= w_opb;
`endif
                    end
                end
                S_BUSY: begin
`ifdef EX_DIV_EN
                    if (r_is_div) begin
                        r_acc <= w_rem_nxt;
                        r_b   <= {r_b[W-2:0], w_rem_ge};
                    end else begin
                        r_acc <= w_mul_acc_nxt;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                    end
`else
                    r_acc <= w_mul_acc_nxt;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
`endif
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // EX/MEM boundary: bubble, long-op writeback, or single-cycle result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_out        <= 1'b0;
            jump_out          <= 1'b0;
            MemRead_out       <= 1'b0;
            MemWrite_out      <= 1'b0;
            RegWrite_out      <= 1'b0;
            MemtoReg_out      <= 1'b0;
            alu_result_out    <= '0;
            zero_out          <= 1'b0;
            branch_target_out <= '0;
            readdata2_out     <= '0;
            write_reg_out     <= '0;
        end else if (w_bubble) begin
            branch_out   <= 1'b0;
            jump_out     <= 1'b0;
            MemRead_out  <= 1'b0;
            MemWrite_out <= 1'b0;
            RegWrite_out <= 1'b0;
            MemtoReg_out <= 1'b0;
        end else if (r_state == S_DONE) begin
            {branch_out, jump_out, MemRead_out, MemWrite_out, RegWrite_out, MemtoReg_out} <= r_h_ctl;
            alu_result_out    <= w_iter_res;
            zero_out          <= (w_iter_res == '0);
            branch_target_out <= r_h_tgt;
            readdata2_out     <= r_h_rd2;
            write_reg_out     <= r_h_wreg;
        end else begin
            branch_out        <= branch;
            jump_out          <= jump;
            MemRead_out       <= MemRead;
            MemWrite_out      <= MemWrite;
            RegWrite_out      <= RegWrite;
            MemtoReg_out      <= MemtoReg;
            alu_result_out    <= w_alu;
            zero_out          <= (w_alu == '0);
            branch_target_out <= w_target;
            readdata2_out     <= readdata2;
            write_reg_out     <= w_wreg;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Directed self-checking bench for ex_stage: a vector table for
//                single-cycle ops plus sequences for MULT/DIVU, flush and
//                asynchronous reset during an iterative op. Honors EX_DIV_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        branch = 1'b0, jump = 1'b0, AluSrc = 1'b0, MemRead = 1'b0;
    logic        MemWrite = 1'b0, RegWrite = 1'b0, RegDst = 1'b0, MemtoReg = 1'b0;
    logic [5:0]  AluOp = 6'h20;
    logic [31:0] npc = '0, readdata1 = '0, readdata2 = '0, sigext = '0;
    logic [4:0]  instruction_2016 = 5'd3, instruction_1511 = 5'd9;
    logic        stall;
    logic        branch_out, jump_out, MemRead_out, MemWrite_out, RegWrite_out, MemtoReg_out;
    logic [31:0] alu_result_out, branch_target_out, readdata2_out;
    logic        zero_out;
    logic [4:0]  write_reg_out;

    int tests = 0;
    int fails = 0;

    ex_stage #(.W(32), .ITERS(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .branch(branch), .jump(jump), .AluSrc(AluSrc), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .AluOp(AluOp), .npc(npc), .readdata1(readdata1), .readdata2(readdata2),
        .sigext(sigext), .instruction_2016(instruction_2016),
        .instruction_1511(instruction_1511), .stall(stall),
        .branch_out(branch_out), .jump_out(jump_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .RegWrite_out(RegWrite_out),
        .MemtoReg_out(MemtoReg_out), .alu_result_out(alu_result_out),
        .zero_out(zero_out), .branch_target_out(branch_target_out),
        .readdata2_out(readdata2_out), .write_reg_out(write_reg_out)
    );

    always #5 clk = ~clk;

    logic [5:0] ctl_o;
    assign ctl_o = {branch_out, jump_out, MemRead_out, MemWrite_out, RegWrite_out, MemtoReg_out};

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        src;
        logic [31:0] sx;
        logic [31:0] npc;
        logic [5:0]  ctl;
        logic        regdst;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic [31:0] sx, input logic [31:0] pc,
                         input logic [5:0] ctl, input logic rdst);
        AluOp = op; readdata1 = a; readdata2 = b; AluSrc = src; sigext = sx; npc = pc;
        {branch, jump, MemRead, MemWrite, RegWrite, MemtoReg} = ctl;
        RegDst = rdst;
    endtask

    // Issue a long op, count stall cycles and bubbles, then check the writeback.
    task automatic run_iter(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input string nm);
        int n;
        int bub;
        apply(op, a, b, 1'b0, 32'h0, 32'h0, 6'b000010, 1'b1);
        #1;
        chk({nm, " stall at issue"}, {31'b0, stall}, 32'd1);
        n = 0;
        bub = 0;
        while (stall === 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (ctl_o !== 6'b0) bub++;
        end
        chk({nm, " stall cycles"}, n, 33);
        chk({nm, " bubbles"}, bub, 0);
        @(posedge clk); #1;
        chk({nm, " result"}, alu_result_out, exp);
        chk({nm, " ctl"}, {26'b0, ctl_o}, {26'b0, 6'b000010});
        chk({nm, " wreg"}, {27'b0, write_reg_out}, 32'd9);
    endtask

    initial begin
        int n;
        int bad;

        //         op     a             b             src  sx            npc           ctl        rd   res           z     tgt
        vecs[0]  = '{6'h20, 32'd5,        32'd7,        1'b0, 32'h0,        32'h0,        6'b000010, 1'b1, 32'd12,       1'b0, 32'h0};
        vecs[1]  = '{6'h22, 32'd3,        32'd3,        1'b0, 32'h4,        32'h100,      6'b100000, 1'b0, 32'd0,        1'b1, 32'h110};
        vecs[2]  = '{6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h0,        32'h0,        6'b001011, 1'b0, 32'h00F000F0, 1'b0, 32'h0};
        vecs[3]  = '{6'h25, 32'hF0000000, 32'h0000000F, 1'b0, 32'h0,        32'h0,        6'b000100, 1'b1, 32'hF000000F, 1'b0, 32'h0};
        vecs[4]  = '{6'h26, 32'hAAAAAAAA, 32'hFFFF0000, 1'b0, 32'h0,        32'h0,        6'b010010, 1'b0, 32'h5555AAAA, 1'b0, 32'h0};
        vecs[5]  = '{6'h27, 32'h0,        32'h0000FFFF, 1'b0, 32'h0,        32'h0,        6'b000010, 1'b1, 32'hFFFF0000, 1'b0, 32'h0};
        vecs[6]  = '{6'h2A, 32'hFFFFFFFF, 32'd1,        1'b0, 32'h0,        32'h0,        6'b000010, 1'b0, 32'd1,        1'b0, 32'h0};
        vecs[7]  = '{6'h2A, 32'd5,        32'd3,        1'b0, 32'h0,        32'h0,        6'b000010, 1'b1, 32'd0,        1'b1, 32'h0};
        vecs[8]  = '{6'h00, 32'h0,        32'd1,        1'b0, 32'h100,      32'h0,        6'b000010, 1'b0, 32'h10,       1'b0, 32'h400};
        vecs[9]  = '{6'h02, 32'h0,        32'h80000000, 1'b0, 32'h7C0,      32'h0,        6'b000010, 1'b1, 32'd1,        1'b0, 32'h1F00};
        vecs[10] = '{6'h20, 32'hFFFFFFFF, 32'h1234,     1'b1, 32'h1,        32'h0,        6'b000011, 1'b0, 32'd0,        1'b1, 32'h4};
        vecs[11] = '{6'h3F, 32'd5,        32'd7,        1'b0, 32'h0,        32'h0,        6'b000010, 1'b1, 32'd0,        1'b1, 32'h0};
        vecs[12] = '{6'h22, 32'd0,        32'd1,        1'b0, 32'h4,        32'hFFFFFFF0, 6'b100000, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0};
        vecs[13] = '{6'h2A, 32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h0,        32'h0,        6'b000010, 1'b1, 32'd1,        1'b0, 32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctl", {26'b0, ctl_o}, 32'd0);
        chk("reset result", alu_result_out, 32'd0);
        chk("reset stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single-cycle table
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].src, vecs[i].sx,
                  vecs[i].npc, vecs[i].ctl, vecs[i].regdst);
            #1;
            chk($sformatf("v%0d stall", i), {31'b0, stall}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d result", i), alu_result_out, vecs[i].exp_res);
            chk($sformatf("v%0d zero", i), {31'b0, zero_out}, {31'b0, vecs[i].exp_zero});
            chk($sformatf("v%0d target", i), branch_target_out, vecs[i].exp_tgt);
            chk($sformatf("v%0d ctl", i), {26'b0, ctl_o}, {26'b0, vecs[i].ctl});
            chk($sformatf("v%0d rd2", i), readdata2_out, vecs[i].b);
            chk($sformatf("v%0d wreg", i), {27'b0, write_reg_out},
                vecs[i].regdst ? 32'd9 : 32'd3);
        end

        // Back-to-back long ops
        run_iter(6'h18, 32'd6, 32'd7, 32'd42, "mult 6x7");
        run_iter(6'h18, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, "mult ffffffffx2");
        run_iter(6'h18, 32'h00010001, 32'h00010001, 32'h00020001, "mult wrap");

`ifdef EX_DIV_EN
        run_iter(6'h1A, 32'd100, 32'd7, 32'd14, "divu 100/7");
        run_iter(6'h1A, 32'd5, 32'd0, 32'hFFFFFFFF, "divu 5/0");
`else
        apply(6'h1A, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 6'b000010, 1'b1);
        #1;
        chk("divu off stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("divu off result", alu_result_out, 32'd0);
        chk("divu off ctl", {26'b0, ctl_o}, {26'b0, 6'b000010});
        chk("divu off stall after", {31'b0, stall}, 32'd0);
`endif

        // Flush on BUSY cycle 10, then an ADD completes normally
        apply(6'h18, 32'd6, 32'd7, 1'b0, 32'h0, 32'h0, 6'b000010, 1'b1);
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        apply(6'h20, 32'd1, 32'd2, 1'b0, 32'h0, 32'h0, 6'b000010, 1'b1);
        #1;
        chk("flush stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk("flush bubble", {26'b0, ctl_o}, 32'd0);
        chk("flush idle", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("post-flush add", alu_result_out, 32'd3);
        chk("post-flush ctl", {26'b0, ctl_o}, {26'b0, 6'b000010});

        // Asynchronous reset in the middle of a MULT
        apply(6'h18, 32'd6, 32'd7, 1'b0, 32'h0, 32'h0, 6'b000010, 1'b1);
        repeat (5) begin @(posedge clk); #1; end
        #2;
        rst = 1'b0;
        #1;
        chk("async rst ctl", {26'b0, ctl_o}, 32'd0);
        chk("async rst result", alu_result_out, 32'd0);
        chk("async rst rd2", readdata2_out, 32'd0);
        chk("async rst stall", {31'b0, stall}, 32'd0);
        apply(6'h20, 32'd0, 32'd0, 1'b0, 32'h0, 32'h0, 6'b000000, 1'b0);
        #3;
        rst = 1'b1;
        bad = 0;
        for (n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (ctl_o !== 6'b0 || alu_result_out !== 32'd0 || stall !== 1'b0) bad++;
        end
        chk("no result after reset", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
